// File: rtl/comparador_serial.sv
// comparador_serial
//   Bit-serial magnitude comparator. Operands are walked LSB-first, one bit per
//   clock, so the most significant differing bit is the last one to overwrite the
//   partial less/greater flags and therefore decides the result. Supports
//   unsigned and two's-complement compares. Result is available N+1 edges after
//   an accepted start and is held until the next completed compare.
//
// Parameters
//   N          operand width in bits (N >= 2)
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over start)
//   start      compare request, accepted only while busy=0
//   A, B       operands, captured on the accepted start edge
//   con_signo  1 = two's-complement compare, 0 = unsigned; captured with A/B
//   busy       high while a compare is in progress
//   done       one-cycle pulse when menor/igual/mayor are updated
//   menor      A < B for the last completed compare
//   igual      A == B for the last completed compare
//   mayor      A > B for the last completed compare
module comparador_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         con_signo,
  output logic         busy,
  output logic         done,
  output logic         menor,
  output logic         igual,
  output logic         mayor
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [N-1:0]  sa, sb;
  logic          sg;
  logic          lt, gt;
  logic [CW-1:0] cnt;

  // Next partial flags for the bit currently at position 0.
  logic a, b, inv, lt_n, gt_n;

  always_comb begin
    a    = sa[0];
    b    = sb[0];
    // The sign bit carries negative weight: a 1 there makes the operand smaller.
    inv  = sg && (cnt == LAST);
    lt_n = lt;
    gt_n = gt;
    if (a != b) begin
      lt_n = inv ? (a & ~b) : (~a & b);
      gt_n = inv ? (~a & b) : (a & ~b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sg    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      menor <= 1'b0;
      igual <= 1'b0;
      mayor <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= A;
            sb    <= B;
            sg    <= con_signo;
            lt    <= 1'b0;
            gt    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          lt <= lt_n;
          gt <= gt_n;
          if (cnt == LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            menor <= lt_n;
            mayor <= gt_n;
            igual <= ~lt_n & ~gt_n;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial.sv
module tb_comparador_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A, B;
  logic         con_signo;
  logic         busy, done, menor, igual, mayor;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cycle  = 0;

  comparador_serial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .con_signo(con_signo),
    .busy(busy), .done(done), .menor(menor), .igual(igual), .mayor(mayor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (passed=%0d total=%0d)", passed, total);
    $fatal(1);
  end

  // Independent reference: {menor, igual, mayor}.
  function automatic logic [2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic s);
    logic l, g;
    if (s) begin
      l = $signed(a) < $signed(b);
      g = $signed(a) > $signed(b);
    end else begin
      l = a < b;
      g = a > b;
    end
    return {l, ~l & ~g, g};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start with the given operands and check the whole handshake.
  // Returns in the done cycle (start is low).
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [2:0] exp, input string name);
    logic tbad;
    tbad = 1'b0;
    start = 1'b1; A = a; B = b; con_signo = s;
    tick();
    start = 1'b0;
    A = N'($urandom); B = N'($urandom); con_signo = 1'($urandom);
    for (int k = 0; k < N; k++) begin
      if (k > 0) tick();
      if (busy !== 1'b1 || done !== 1'b0) tbad = 1'b1;
    end
    tick();
    total++;
    if (tbad || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL %s timing: busy=%b done=%b early_violation=%b, required busy=0 done=1",
               name, busy, done, tbad);
    else passed++;
    total++;
    if ({menor, igual, mayor} !== exp)
      $display("FAIL %s result: a=%0d b=%0d s=%b got mei=%b required %b",
               name, a, b, s, {menor, igual, mayor}, exp);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 4'd3; B = 4'd5; con_signo = 1'b0;
    tick(); tick();
    total++;
    if ({busy, done, menor, igual, mayor} !== 5'b0)
      $display("FAIL reset: outputs=%b required 00000", {busy, done, menor, igual, mayor});
    else passed++;
    rst = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    do_op(4'd3, 4'd5, 1'b0, 3'b100, "unsigned_3_5");
    tick();
    total++;
    if (done !== 1'b0)
      $display("FAIL done_pulse_width: done=%b required 0", done);
    else passed++;
    total++;
    if ({menor, igual, mayor} !== 3'b100)
      $display("FAIL result_hold: got %b required 100", {menor, igual, mayor});
    else passed++;
    do_op(4'd14, 4'd7, 1'b0, 3'b001, "unsigned_14_7");
    tick();
  endtask

  task automatic test_equal_sign();
    do_op(4'd9, 4'd9, 1'b0, 3'b010, "equal_9_9");
    tick();
    do_op(4'b1000, 4'b0001, 1'b0, 3'b001, "unsigned_8_1");
    tick();
    do_op(4'b1000, 4'b0001, 1'b1, 3'b100, "signed_m8_1");
    tick();
    do_op(4'b1111, 4'b1110, 1'b1, 3'b001, "signed_m1_m2");
    tick();
  endtask

  task automatic test_busy_guard();
    int unsigned dones;
    start = 1'b1; A = 4'd12; B = 4'd5; con_signo = 1'b0;
    tick();                                   // edge t accepts
    start = 1'b0; A = 4'd0; B = 4'd15;
    tick();                                   // edge t+1
    start = 1'b1;                             // sampled at t+2 while busy
    tick();
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) begin
        dones++;
        total++;
        if ({menor, igual, mayor} !== 3'b001)
          $display("FAIL busy_guard result: got %b required 001", {menor, igual, mayor});
        else passed++;
      end
      tick();
    end
    total++;
    if (dones != 1)
      $display("FAIL busy_guard done_count: got %0d required 1", dones);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    int unsigned dones;
    // leave a nonzero result behind so clearing is visible
    do_op(4'd2, 4'd2, 1'b0, 3'b010, "pre_reset_eq");
    tick();
    start = 1'b1; A = 4'd1; B = 4'd6; con_signo = 1'b0;
    tick();                                   // edge t
    start = 1'b0;
    tick();                                   // edge t+1
    rst = 1'b1;
    tick();                                   // edge t+2 resets
    rst = 1'b0;
    total++;
    if ({busy, done, menor, igual, mayor} !== 5'b0)
      $display("FAIL reset_mid_op outputs: got %b required 00000",
               {busy, done, menor, igual, mayor});
    else passed++;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    total++;
    if (dones != 0)
      $display("FAIL reset_mid_op activity: cycles_with_done_or_busy=%0d required 0", dones);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int unsigned c1, c2;
    do_op(4'd6, 4'd2, 1'b0, 3'b001, "b2b_first");
    c1 = cycle;
    do_op(4'd2, 4'd6, 1'b0, 3'b100, "b2b_second");
    c2 = cycle;
    total++;
    if (c2 - c1 != 5)
      $display("FAIL back_to_back spacing: got %0d cycles required 5", c2 - c1);
    else passed++;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [2:0] r;
    for (int unsigned s = 0; s < 2; s++)
      for (int unsigned a = 0; a < 16; a++)
        for (int unsigned b = 0; b < 16; b++) begin
          do_op(4'(a), 4'(b), 1'(s), model(4'(a), 4'(b), 1'(s)), "exhaustive");
          r = {menor, igual, mayor};
          total++;
          if (!$onehot(r))
            $display("FAIL exhaustive onehot: got %b required one-hot", r);
          else passed++;
        end
    tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; A = '0; B = '0; con_signo = 1'b0;
    test_reset();
    test_unsigned();
    test_equal_sign();
    test_busy_guard();
    test_reset_mid_op();
    test_back_to_back();
    test_exhaustive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
